prco_loader: RTL and testbench

Serial program loader that writes instruction words into the core's local memory from a framed byte stream. It sits between a byte source (UART receiver or debug link) and the local-memory write port. While a frame is in progress it holds the core in reset, and it releases the core only after a frame passes its checksum. It is the writer counterpart of the core's instruction-fetch read path.

---
 rtl/prco_loader_if.sv | 20 ++
 rtl/prco_loader.sv | 171 +++++++++++++++++
 tb/tb_prco_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prco_loader_if.sv
// Byte-stream input and local-memory write port of the program loader.
// master = byte source / memory side, slave = the loader.
interface prco_loader_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        q_rx_ready;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_dina;

    modport master (
        output i_rx_valid, i_rx_data,
        input  q_rx_ready, q_mem_we, q_mem_addr, q_mem_dina
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output q_rx_ready, q_mem_we, q_mem_addr, q_mem_dina
    );
endinterface

// File: rtl/prco_loader.sv
// Framed serial program loader: writes words into core local memory and holds
// the core in reset until a frame passes its checksum.
//
// state   | meaning
// IDLE    | waiting for SYNC_BYTE, other bytes discarded
// BASE_HI | expecting start address high byte
// BASE_LO | expecting start address low byte
// LEN_HI  | expecting word count high byte
// LEN_LO  | expecting word count low byte
// DATA_HI | expecting data word high byte
// DATA_LO | expecting data word low byte
// WRITE   | one-cycle memory write strobe, input stalled
// CSUM    | expecting checksum byte
module prco_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    prco_loader_if.slave bus,
    output logic         q_core_reset,
    output logic         q_busy,
    output logic         q_done,
    output logic         q_error,
    output logic [1:0]   q_err_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BASE_HI,
        S_BASE_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM
    } state_t;

    // Firing one count early lets the timeout land exactly when the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_rx_ready;
    logic        w_consume;
    logic        w_timeout;
    logic        w_mem_we;
    logic [7:0]  w_sum;
    logic [7:0]  r_csum;
    logic [15:0] r_addr;
    logic [15:0] r_count;
    logic [15:0] r_word;
    logic [31:0] r_timer;
    logic        r_core_reset;
    logic        r_done;
    logic        r_error;
    logic [1:0]  r_err_code;

    assign w_sum = r_csum + bus.i_rx_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = (r_state != S_WRITE);
        w_consume   = bus.i_rx_valid & w_rx_ready;
        w_mem_we    = (r_state == S_WRITE);
        w_timeout   = (r_state != S_IDLE) && !w_consume && (r_timer == TC_LAST);
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_consume && bus.i_rx_data == SYNC_BYTE) w_state_nxt = S_BASE_HI;
                S_BASE_HI: if (w_consume) w_state_nxt = S_BASE_LO;
                S_BASE_LO: if (w_consume) w_state_nxt = S_LEN_HI;
                S_LEN_HI:  if (w_consume) w_state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if (w_consume) begin
                        w_state_nxt = ({r_count[15:8], bus.i_rx_data} != 16'd0) ? S_DATA_HI : S_CSUM;
                    end
                end
                S_DATA_HI: if (w_consume) w_state_nxt = S_DATA_LO;
                S_DATA_LO: if (w_consume) w_state_nxt = S_WRITE;
                S_WRITE:   w_state_nxt = (r_count != 16'd1) ? S_DATA_HI : S_CSUM;
                S_CSUM:    if (w_consume) w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_csum       <= 8'd0;
            r_addr       <= 16'd0;
            r_count      <= 16'd0;
            r_word       <= 16'd0;
            r_timer      <= 32'd0;
            r_core_reset <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            if (r_state == S_IDLE || w_consume || w_timeout) begin
                r_timer <= 32'd0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            if (w_consume && r_state != S_IDLE) begin
                r_csum <= w_sum;
            end

            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + 16'd1;
                r_count <= r_count - 16'd1;
            end

            if (w_timeout) begin
                r_error    <= 1'b1;
                r_err_code <= 2'd2;
            end else if (w_consume) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_rx_data == SYNC_BYTE) begin
                            r_csum       <= 8'd0;
                            r_core_reset <= 1'b1;
                            r_done       <= 1'b0;
                            r_error      <= 1'b0;
                            r_err_code   <= 2'd0;
                        end
                    end
                    S_BASE_HI: r_addr[15:8]  <= bus.i_rx_data;
                    S_BASE_LO: r_addr[7:0]   <= bus.i_rx_data;
                    S_LEN_HI:  r_count[15:8] <= bus.i_rx_data;
                    S_LEN_LO:  r_count[7:0]  <= bus.i_rx_data;
                    S_DATA_HI: r_word[15:8]  <= bus.i_rx_data;
                    S_DATA_LO: r_word[7:0]   <= bus.i_rx_data;
                    S_CSUM: begin
                        if (w_sum == 8'd0) begin
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset must suppress a strobe already showing in the WRITE cycle.
    assign bus.q_mem_we   = w_mem_we & ~i_reset;
    assign bus.q_rx_ready = w_rx_ready;
    assign bus.q_mem_addr = r_addr;
    assign bus.q_mem_dina = r_word;
    assign q_core_reset   = r_core_reset;
    assign q_busy         = (r_state != S_IDLE);
    assign q_done         = r_done;
    assign q_error        = r_error;
    assign q_err_code     = r_err_code;

endmodule

// File: tb/tb_prco_loader.sv
// Bench for prco_loader: frames are built from the checksum rule and compared
// against an expected write list and status outcome.
module tb_prco_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_reset, busy, done, error;
    logic [1:0] err_code;

    prco_loader_if bus();

    prco_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(100)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .bus          (bus),
        .q_core_reset (core_reset),
        .q_busy       (busy),
        .q_done       (done),
        .q_error      (error),
        .q_err_code   (err_code)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_stall = 0;
    logic [7:0]  tx_q[$];
    logic [15:0] words_q[$];
    logic [31:0] exp_wr[$];
    logic [31:0] got_wr[$];
    int          got_cyc[$];
    int          cons_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.q_mem_we === 1'b1) begin
            got_wr.push_back({bus.q_mem_addr, bus.q_mem_dina});
            got_cyc.push_back(cyc);
        end
        if (bus.q_rx_ready === 1'b0) n_stall++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: frame bytes, expected writes (address wraps mod 2^16) and checksum.
    task automatic make_frame(input logic [15:0] base, input bit bad);
        logic [7:0]  sum;
        logic [15:0] a;
        int          n;
        n = words_q.size();
        tx_q.delete();
        exp_wr.delete();
        a = base;
        sum = 8'd0;
        tx_q.push_back(SYNC);
        tx_q.push_back(base[15:8]);
        tx_q.push_back(base[7:0]);
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
        foreach (words_q[i]) begin
            tx_q.push_back(words_q[i][15:8]);
            tx_q.push_back(words_q[i][7:0]);
            exp_wr.push_back({a, words_q[i]});
            a = a + 16'd1;
        end
        for (int i = 1; i < tx_q.size(); i++) sum = sum + tx_q[i];
        tx_q.push_back(bad ? 8'(8'd0 - sum + 8'd1) : 8'(8'd0 - sum));
    endtask

    function automatic int wr_diff();
        int d;
        if (got_wr.size() != exp_wr.size()) return 1000;
        d = 0;
        foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) d++;
        return d;
    endfunction

    // Presents one byte after 'gap' idle cycles; returns just after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  waited;
        bit  acc;
        if (gap > 0) begin
            bus.i_rx_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        waited = 0;
        forever begin
            @(negedge clk);
            acc = bus.q_rx_ready;
            @(posedge clk); #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL byte_accept_bound byte=%02h waited=%0d required<=50", b, waited);
                break;
            end
        end
        cons_cyc.push_back(cyc);
    endtask

    task automatic send_frame(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++) send_byte(tx_q[i], $urandom_range(0, maxgap));
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.q_rx_ready, bus.q_mem_we, bus.q_mem_addr, bus.q_mem_dina, core_reset, busy, done, error, err_code}
            !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_values addr=%h dina=%h cr=%b busy=%b done=%b err=%b code=%0d required all zero, ready=1",
                     bus.q_mem_addr, bus.q_mem_dina, core_reset, busy, done, error, err_code);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, core_reset, bus.q_rx_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_release busy=%b cr=%b ready=%b required 0 0 1", busy, core_reset, bus.q_rx_ready);
        end
    endtask

    task automatic test_basic();
        got_wr.delete();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        bus.i_rx_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_garbage busy=%b required 0", busy);
        end
        words_q = '{16'h1234, 16'hABCD};
        make_frame(16'h0010, 1'b0);
        send_frame(0, 0, 0);
        n_checks++;
        if ({busy, core_reset, done} !== 3'b110) begin
            n_errors++;
            $display("FAIL basic_sync busy=%b cr=%b done=%b required 1 1 0", busy, core_reset, done);
        end
        send_frame(1, tx_q.size() - 1, 2);
        n_checks++;
        if (wr_diff() != 0) begin
            n_errors++;
            $display("FAIL basic_writes got_n=%0d required_n=%0d diffs=%0d", got_wr.size(), exp_wr.size(), wr_diff());
        end
        n_checks++;
        if ({done, error, err_code, core_reset, busy} !== 6'b100000) begin
            n_errors++;
            $display("FAIL basic_status done=%b err=%b code=%0d cr=%b busy=%b required 1 0 0 0 0",
                     done, error, err_code, core_reset, busy);
        end
    endtask

    task automatic test_empty_and_wrap();
        got_wr.delete();
        words_q.delete();
        make_frame(16'h0000, 1'b0);
        send_frame(0, tx_q.size() - 1, 0);
        n_checks++;
        if ({got_wr.size() == 0, done, busy} !== 3'b110) begin
            n_errors++;
            $display("FAIL empty_frame writes=%0d done=%b busy=%b required 0 1 0", got_wr.size(), done, busy);
        end
        got_wr.delete();
        words_q = '{16'h1111, 16'h2222};
        make_frame(16'hFFFF, 1'b0);
        send_frame(0, tx_q.size() - 1, 1);
        n_checks++;
        if (wr_diff() != 0 || got_wr.size() != 2 || got_wr[1][31:16] !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_writes got_n=%0d required_n=2 diffs=%0d", got_wr.size(), wr_diff());
        end
        n_checks++;
        if ({done, error, core_reset} !== 3'b100) begin
            n_errors++;
            $display("FAIL wrap_status done=%b err=%b cr=%b required 1 0 0", done, error, core_reset);
        end
    endtask

    task automatic test_bad_csum();
        got_wr.delete();
        words_q = '{16'h1234, 16'hABCD};
        make_frame(16'h0010, 1'b1);
        send_frame(0, tx_q.size() - 1, 2);
        n_checks++;
        if (wr_diff() != 0) begin
            n_errors++;
            $display("FAIL bad_writes got_n=%0d required_n=%0d", got_wr.size(), exp_wr.size());
        end
        n_checks++;
        if ({done, error, err_code, core_reset} !== 5'b01011) begin
            n_errors++;
            $display("FAIL bad_status done=%b err=%b code=%0d cr=%b required 0 1 1 1", done, error, err_code, core_reset);
        end
        got_wr.delete();
        make_frame(16'h0010, 1'b0);
        send_frame(0, 0, 0);
        n_checks++;
        if ({error, err_code, core_reset} !== 4'b0001) begin
            n_errors++;
            $display("FAIL recover_sync err=%b code=%0d cr=%b required 0 0 1", error, err_code, core_reset);
        end
        send_frame(1, tx_q.size() - 1, 1);
        n_checks++;
        if ({done, error, core_reset} !== 3'b100 || wr_diff() != 0) begin
            n_errors++;
            $display("FAIL recover_status done=%b err=%b cr=%b diffs=%0d required 1 0 0 0", done, error, core_reset, wr_diff());
        end
    endtask

    task automatic test_random();
        bit         bad;
        logic [7:0] g;
        for (int f = 0; f < 6; f++) begin
            got_wr.delete();
            words_q.delete();
            repeat ($urandom_range(0, 5)) words_q.push_back(16'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            make_frame(16'($urandom), bad);
            g = 8'($urandom_range(0, 255));
            if (g == SYNC) g = 8'h00;
            send_byte(g, $urandom_range(0, 2));
            send_frame(0, tx_q.size() - 1, 3);
            n_checks++;
            if (wr_diff() != 0) begin
                n_errors++;
                $display("FAIL random_writes frame=%0d got_n=%0d required_n=%0d diffs=%0d",
                         f, got_wr.size(), exp_wr.size(), wr_diff());
            end
            n_checks++;
            if ({done, error, err_code, core_reset, busy} !== (bad ? 6'b010110 : 6'b100000)) begin
                n_errors++;
                $display("FAIL random_status frame=%0d bad=%0d done=%b err=%b code=%0d cr=%b busy=%b",
                         f, bad, done, error, err_code, core_reset, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  stall0;
        bit  cyc_ok;
        got_wr.delete();
        got_cyc.delete();
        cons_cyc.delete();
        words_q = '{16'h1234, 16'hABCD};
        make_frame(16'h0010, 1'b0);
        stall0 = n_stall;
        send_frame(0, tx_q.size() - 1, 0);
        n_checks++;
        if (cons_cyc[cons_cyc.size() - 1] - cons_cyc[0] != 11) begin
            n_errors++;
            $display("FAIL b2b_span cycles=%0d required 11", cons_cyc[cons_cyc.size() - 1] - cons_cyc[0]);
        end
        n_checks++;
        if (n_stall - stall0 != 2) begin
            n_errors++;
            $display("FAIL b2b_stalls got=%0d required 2", n_stall - stall0);
        end
        cyc_ok = (got_cyc.size() == 2) && (wr_diff() == 0);
        if (cyc_ok) cyc_ok = (got_cyc[0] == cons_cyc[6]) && (got_cyc[1] == cons_cyc[8]);
        n_checks++;
        if (!cyc_ok) begin
            n_errors++;
            $display("FAIL b2b_write_timing writes=%0d diffs=%0d required writes in cycle after each low byte",
                     got_cyc.size(), wr_diff());
        end
        got_wr.delete();
        send_frame(0, 6, 0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.q_mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_write we=%b required 0", bus.q_mem_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.q_rx_ready, bus.q_mem_we, bus.q_mem_addr, bus.q_mem_dina, core_reset, busy, done, error, err_code}
            !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_after_write addr=%h dina=%h cr=%b busy=%b done=%b err=%b code=%0d required reset values",
                     bus.q_mem_addr, bus.q_mem_dina, core_reset, busy, done, error, err_code);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (got_wr.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_strobe writes=%0d busy=%b required 0 0", got_wr.size(), busy);
        end
    endtask

    task automatic test_timeout();
        words_q = '{16'h1234, 16'hABCD};
        make_frame(16'h0010, 1'b0);
        send_frame(0, 4, 1);
        repeat (98) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, err_code} !== 3'b100) begin
            n_errors++;
            $display("FAIL timeout_early busy=%b code=%0d required 1 0", busy, err_code);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, error, err_code, core_reset} !== 5'b01101) begin
            n_errors++;
            $display("FAIL timeout_status busy=%b err=%b code=%0d cr=%b required 0 1 2 1", busy, error, err_code, core_reset);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_and_wrap();
        test_bad_csum();
        test_random();
        test_back_to_back();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
